// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, write request type and register-zero address for the write-back stage
package wb_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if: ALU/load source handshakes and register-bank write port of the write-back stage
interface wb_write_arbiter_if #(parameter int FIFO_DEPTH = 4);
    import wb_pkg::*;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic alu_valid, alu_ready, mem_valid, mem_ready, rf_we, busy;
    logic [ADDR_W-1:0] alu_addr, mem_addr, rf_waddr;
    logic [DATA_W-1:0] alu_data, mem_data, rf_wdata;
    logic [CW-1:0] fifo_count;
    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        input alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, fifo_count, busy
    );
    modport slave (
        input alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready, rf_we, rf_waddr, rf_wdata, fifo_count, busy
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of write requests; DEPTH must be a power of two so pointers wrap naturally
module wb_fifo import wb_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_req_t                    din,
    input  logic                       pop,
    output wb_req_t                    dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    wb_req_t mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic do_push, do_pop;
    always_comb begin
        full = count == (PW+1)'(DEPTH);
        empty = count == '0;
        do_push = push && !full;
        do_pop = pop && !empty;
        dout = mem[rptr];
    end
    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= din;
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= wptr + PW'(do_push);
            rptr <= rptr + PW'(do_pop);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges ALU results and FIFO-buffered load results onto the register-bank write port
// ALU has priority up to MAX_STARVE wins while loads wait; define WB_ZERO_SUPPRESS_EN to never write R0.
module wb_write_arbiter import wb_pkg::*; #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_STARVE = 3
) (
    input logic clk,
    input logic rst,
    wb_write_arbiter_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    wb_req_t head, win;
    logic full, empty, starved, alu_win, pop, wr, rf_we;
    logic [CW-1:0] count;
    logic [3:0] starve_cnt;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(bus.mem_valid),
        .din(wb_req_t'{bus.mem_addr, bus.mem_data}),
        .pop(pop),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
    always_comb begin
        starved = !empty && starve_cnt == 4'(MAX_STARVE);
        alu_win = bus.alu_valid && !starved;
        pop = !alu_win && !empty;
        win = alu_win ? wb_req_t'{bus.alu_addr, bus.alu_data} : head;
`ifdef WB_ZERO_SUPPRESS_EN
        wr = (alu_win || pop) && win.addr != REG_ZERO;
`else
        wr = alu_win || pop;
`endif
    end
    // an ALU win with loads waiting can only happen below the limit, so the count saturates by itself
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            starve_cnt <= '0;
        end else begin
            rf_we <= wr;
            if (wr) {rf_waddr, rf_wdata} <= win;
            starve_cnt <= (pop || empty) ? '0 : starve_cnt + 4'd1;
        end
    end
    assign bus.alu_ready = !starved;
    assign bus.mem_ready = !full;
    assign bus.rf_we = rf_we;
    assign bus.rf_waddr = rf_waddr;
    assign bus.rf_wdata = rf_wdata;
    assign bus.fifo_count = count;
    assign bus.busy = count != '0 || rf_we;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed-vector bench for wb_write_arbiter (FIFO_DEPTH=4, MAX_STARVE=3)
// A cycle starts 1ns after a rising edge (inputs driven) and is sampled on the falling edge.
module tb_wb_write_arbiter;
    import wb_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    wb_req_t seen [$];
    wb_write_arbiter_if #(.FIFO_DEPTH(4)) bus ();
    wb_write_arbiter #(.FIFO_DEPTH(4), .MAX_STARVE(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(negedge clk)
        if (mon_en && bus.rf_we && bus.rf_waddr >= 5'd1 && bus.rf_waddr <= 5'd5)
            seen.push_back(wb_req_t'{bus.rf_waddr, bus.rf_wdata});
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic next();
        @(posedge clk);
        #1;
    endtask
    task automatic mid();
        @(negedge clk);
    endtask
    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
    endtask
    task automatic alu(input logic [4:0] a, input logic [31:0] d);
        bus.alu_valid = 1'b1;
        bus.alu_addr = a;
        bus.alu_data = d;
    endtask
    task automatic load(input logic [4:0] a, input logic [31:0] d);
        bus.mem_valid = 1'b1;
        bus.mem_addr = a;
        bus.mem_data = d;
    endtask
    initial begin
        int we_seen;
        int p;
        idle();
        bus.alu_addr = '0;
        bus.alu_data = '0;
        bus.mem_addr = '0;
        bus.mem_data = '0;
        repeat (2) next();
        rst = 1'b0;
        mid();
        check("rst_we", bus.rf_we, 0);
        check("rst_waddr", bus.rf_waddr, 0);
        check("rst_wdata", bus.rf_wdata, 0);
        check("rst_mem_ready", bus.mem_ready, 1);
        check("rst_count", bus.fifo_count, 0);
        check("rst_busy", bus.busy, 0);
        // ALU only: one-cycle latency, then hold
        next(); alu(5'd5, 32'hDEADBEEF); mid();
        check("alu_ready", bus.alu_ready, 1);
        next(); idle(); mid();
        check("alu_we", bus.rf_we, 1);
        check("alu_waddr", bus.rf_waddr, 5);
        check("alu_wdata", bus.rf_wdata, 32'hDEADBEEF);
        check("alu_busy", bus.busy, 1);
        next(); mid();
        check("alu_we_off", bus.rf_we, 0);
        check("hold_waddr", bus.rf_waddr, 5);
        check("hold_wdata", bus.rf_wdata, 32'hDEADBEEF);
        check("idle_busy", bus.busy, 0);
        // load only: push, pop-select, write
        next(); load(5'd7, 32'h12345678); mid();
        check("ld_ready", bus.mem_ready, 1);
        check("ld_cnt0", bus.fifo_count, 0);
        next(); idle(); mid();
        check("ld_cnt1", bus.fifo_count, 1);
        check("ld_we1", bus.rf_we, 0);
        check("ld_busy", bus.busy, 1);
        next(); mid();
        check("ld_we2", bus.rf_we, 1);
        check("ld_waddr", bus.rf_waddr, 7);
        check("ld_wdata", bus.rf_wdata, 32'h12345678);
        check("ld_cnt2", bus.fifo_count, 0);
        next(); mid();
        check("ld_we3", bus.rf_we, 0);
        // starvation: ALU every cycle, one load at cycle 0; ALU payload 4 is held while refused
        for (int k = 0; k < 6; k++) begin
            next();
            p = (k == 5) ? 4 : k;
            alu(5'(10 + p), 32'h100 + p);
            if (k == 0) load(5'd3, 32'hCAFE); else bus.mem_valid = 1'b0;
            mid();
            check($sformatf("st_alu_ready%0d", k), bus.alu_ready, k != 4);
            check($sformatf("st_cnt%0d", k), bus.fifo_count, (k >= 1 && k <= 4) ? 1 : 0);
            if (k >= 1) begin
                check($sformatf("st_we%0d", k), bus.rf_we, 1);
                check($sformatf("st_waddr%0d", k), bus.rf_waddr, (k == 5) ? 3 : 10 + k - 1);
                check($sformatf("st_wdata%0d", k), bus.rf_wdata, (k == 5) ? 32'hCAFE : 32'h100 + k - 1);
            end
        end
        next(); idle(); mid();
        check("st_last_waddr", bus.rf_waddr, 14);
        check("st_last_wdata", bus.rf_wdata, 32'h104);
        next();
        // full: ALU continuous, five loads offered from cycle 0, the fifth held while full
        mon_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            next();
            p = (k == 5) ? 4 : k;
            alu(5'(20 + p), 32'h200 + p);
            load(5'(1 + p), 32'h300 + p);
            mid();
            if (k == 4) begin
                check("full_mem_ready4", bus.mem_ready, 0);
                check("full_cnt4", bus.fifo_count, 4);
                check("full_alu_ready4", bus.alu_ready, 0);
            end
            if (k == 5) begin
                check("full_mem_ready5", bus.mem_ready, 1);
                check("full_cnt5", bus.fifo_count, 3);
                check("full_alu_ready5", bus.alu_ready, 1);
            end
        end
        next(); idle();
        repeat (12) next();
        mon_en = 1'b0;
        check("full_nwrites", seen.size(), 5);
        for (int j = 0; j < 5; j++)
            if (j < seen.size()) begin
                check($sformatf("full_addr%0d", j), seen[j].addr, 1 + j);
                check($sformatf("full_data%0d", j), seen[j].data, 32'h300 + j);
            end
        // reset with three buffered loads: they must never be written
        for (int k = 0; k < 4; k++) begin
            next();
            alu(5'd30, 32'h400 + k);
            if (k < 3) load(5'(6 + k), 32'h500 + k); else bus.mem_valid = 1'b0;
            if (k == 3) rst = 1'b1;
            mid();
        end
        check("rr_cnt_before", bus.fifo_count, 3);
        next(); rst = 1'b0; idle(); mid();
        check("rr_cnt", bus.fifo_count, 0);
        check("rr_we", bus.rf_we, 0);
        check("rr_mem_ready", bus.mem_ready, 1);
        check("rr_busy", bus.busy, 0);
        we_seen = 0;
        for (int k = 0; k < 8; k++) begin
            next(); mid();
            if (bus.rf_we) we_seen++;
        end
        check("rr_no_writes", we_seen, 0);
        // register zero: written normally unless suppression is built in
        next(); alu(5'd9, 32'h99); mid();
        next(); alu(5'd0, 32'hABCD); mid();
        check("z_alu_ready", bus.alu_ready, 1);
        next(); idle(); mid();
`ifdef WB_ZERO_SUPPRESS_EN
        check("z_we", bus.rf_we, 0);
        check("z_waddr", bus.rf_waddr, 9);
        check("z_wdata", bus.rf_wdata, 32'h99);
`else
        check("z_we", bus.rf_we, 1);
        check("z_waddr", bus.rf_waddr, 0);
        check("z_wdata", bus.rf_wdata, 32'hABCD);
`endif
        next();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
